// File: rtl/std_cache_snoop_buffer_pkg.sv
// ----------------------------------------------------------------------------
// std_cache_snoop_buffer_pkg
// Shared types for the ACE snoop front-end of the std dcache.
//   snoop_cr_resp_t : CRRESP as a packed struct, bit 0 = DataTransfer
//   CR_*            : bit positions of the CRRESP fields
//   ac_entry_t      : one queued AC snoop {addr, snoop}
//   snoop_state_e   : sequencing states of the snoop front-end
// ----------------------------------------------------------------------------
package std_cache_snoop_buffer_pkg;

  localparam int SNOOP_ADDR_WIDTH = 64;

  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } snoop_cr_resp_t;

  typedef struct packed {
    logic [SNOOP_ADDR_WIDTH-1:0] addr;
    logic [3:0]                  snoop;
  } ac_entry_t;

  typedef enum logic [1:0] {
    SNP_IDLE,
    SNP_WAIT,
    SNP_CR,
    SNP_CD
  } snoop_state_e;

endpackage

// File: rtl/std_cache_snoop_buffer_fifo_v3.sv
// ----------------------------------------------------------------------------
// fifo_v3
// Simple first-word-visible FIFO used for the AC snoop queue.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   flush_i      : synchronous clear of all entries
//   full_o       : no space left (push ignored)
//   empty_o      : nothing stored (pop ignored)
//   data_i/push_i: write side
//   data_o/pop_i : head entry and advance
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fifo_v3 #(
  parameter int  DEPTH = 4,
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  dtype           mem_reg [DEPTH];
  logic [AW-1:0]  wptr_reg;
  logic [AW-1:0]  rptr_reg;
  logic [AW:0]    cnt_reg;
  logic           push_ok;
  logic           pop_ok;

  assign full_o  = (cnt_reg == FULL_CNT);
  assign empty_o = (cnt_reg == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_reg[rptr_reg];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cnt_reg  <= '0;
    end else if (flush_i) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      if (push_ok && !pop_ok)      cnt_reg <= cnt_reg + 1'b1;
      else if (!push_ok && pop_ok) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Storage carries no reset; entries are only observable once written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_reg[wptr_reg] <= data_i;
  end

endmodule

// File: rtl/std_cache_snoop_buffer.sv
// ----------------------------------------------------------------------------
// std_cache_snoop_buffer
// ACE snoop front-end: queues AC snoops, hands them to the dcache one at a
// time, returns the cache result on CR and serialises a returned line on CD.
//   clk_i, rst_ni                       : clock, async active-low reset
//   ac_valid_i/ac_ready_o/ac_addr_i/ac_snoop_i : AC snoop address channel
//   cr_valid_o/cr_ready_i/cr_resp_o     : CR snoop response channel
//   cd_valid_o/cd_ready_i/cd_data_o/cd_last_o  : CD snoop data channel
//   snp_req_valid_o/snp_req_ready_i/snp_req_addr_o/snp_req_snoop_o : to cache
//   snp_resp_valid_i/snp_resp_i/snp_data_i : cache result (one-cycle pulse)
// ----------------------------------------------------------------------------
module std_cache_snoop_buffer
  import std_cache_snoop_buffer_pkg::*;
#(
  parameter int AC_DEPTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 128,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ac_valid_i,
  output logic                  ac_ready_o,
  input  logic [ADDR_WIDTH-1:0] ac_addr_i,
  input  logic [3:0]            ac_snoop_i,
  output logic                  cr_valid_o,
  input  logic                  cr_ready_i,
  output logic [4:0]            cr_resp_o,
  output logic                  cd_valid_o,
  input  logic                  cd_ready_i,
  output logic [DATA_WIDTH-1:0] cd_data_o,
  output logic                  cd_last_o,
  output logic                  snp_req_valid_o,
  input  logic                  snp_req_ready_i,
  output logic [ADDR_WIDTH-1:0] snp_req_addr_o,
  output logic [3:0]            snp_req_snoop_o,
  input  logic                  snp_resp_valid_i,
  input  logic [4:0]            snp_resp_i,
  input  logic [LINE_WIDTH-1:0] snp_data_i
);

  localparam int NBEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam bit NBEATS_OK = (NBEATS >= 2) && ((NBEATS & (NBEATS - 1)) == 0)
                             && (NBEATS * DATA_WIDTH == LINE_WIDTH);

  snoop_state_e                       state_reg, state_next;
  snoop_cr_resp_t                     resp_reg;
  logic [NBEATS-1:0][DATA_WIDTH-1:0]  line_reg;
  logic [BEAT_W-1:0]                  cnt_reg;
  ac_entry_t                          push_entry;
  ac_entry_t                          head;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               pop;
  logic                               resp_load;

  assign push_entry = '{addr: SNOOP_ADDR_WIDTH'(ac_addr_i), snoop: ac_snoop_i};
  assign ac_ready_o = ~fifo_full;

  fifo_v3 #(
    .DEPTH (AC_DEPTH),
    .dtype (ac_entry_t)
  ) i_ac_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (push_entry),
    .push_i  (ac_valid_i),
    .data_o  (head),
    .pop_i   (pop)
  );

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    resp_load  = 1'b0;
    unique case (state_reg)
      SNP_IDLE: begin
        if (!fifo_empty && snp_req_ready_i) begin
          pop        = 1'b1;
          state_next = SNP_WAIT;
        end
      end
      SNP_WAIT: begin
        if (snp_resp_valid_i) begin
          resp_load  = 1'b1;
          state_next = SNP_CR;
        end
      end
      SNP_CR: begin
        if (cr_ready_i) state_next = resp_reg.data_transfer ? SNP_CD : SNP_IDLE;
      end
      SNP_CD: begin
        if (cd_ready_i && cnt_reg == LAST_BEAT) state_next = SNP_IDLE;
      end
      default: state_next = SNP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= SNP_IDLE;
      resp_reg  <= '0;
      line_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (resp_load) begin
        resp_reg <= snp_resp_i;
        line_reg <= snp_data_i;
      end
      // NBEATS is a power of two, so the final increment wraps to beat 0.
      if (cd_valid_o && cd_ready_i) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Valids depend only on registered state and FIFO occupancy, never on a
  // ready input, so there is no combinational ready->valid path.
  assign snp_req_valid_o = (state_reg == SNP_IDLE) && !fifo_empty;
  assign snp_req_addr_o  = snp_req_valid_o ? head.addr[ADDR_WIDTH-1:0] : '0;
  assign snp_req_snoop_o = snp_req_valid_o ? head.snoop : '0;
  assign cr_valid_o      = (state_reg == SNP_CR);
  assign cr_resp_o       = resp_reg;
  assign cd_valid_o      = (state_reg == SNP_CD);
  assign cd_data_o       = line_reg[cnt_reg];
  assign cd_last_o       = cd_valid_o && (cnt_reg == LAST_BEAT);

  a_nbeats: assert property (@(posedge clk_i) NBEATS_OK);

  a_cr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cr_valid_o && !cr_ready_i) |=> (cr_valid_o && $stable(cr_resp_o)));

  a_cd_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cd_valid_o && !cd_ready_i) |=> (cd_valid_o && $stable(cd_data_o) && $stable(cd_last_o)));

  a_resp_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    snp_resp_valid_i |-> (state_reg == SNP_WAIT));

endmodule

// File: tb/tb_std_cache_snoop_buffer.sv
// ----------------------------------------------------------------------------
// tb_std_cache_snoop_buffer
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level model (queue of accepted
// snoops, one outstanding snoop with its response and beats sent).
// ----------------------------------------------------------------------------
module tb_std_cache_snoop_buffer;

  localparam int NBEATS = 2;
  localparam int DW     = 64;
  localparam int LW     = 128;
  localparam int AW     = 64;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ac_valid_i;
  logic          ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0]    ac_snoop_i;
  logic          cr_valid_o;
  logic          cr_ready_i;
  logic [4:0]    cr_resp_o;
  logic          cd_valid_o;
  logic          cd_ready_i;
  logic [DW-1:0] cd_data_o;
  logic          cd_last_o;
  logic          snp_req_valid_o;
  logic          snp_req_ready_i;
  logic [AW-1:0] snp_req_addr_o;
  logic [3:0]    snp_req_snoop_o;
  logic          snp_resp_valid_i;
  logic [4:0]    snp_resp_i;
  logic [LW-1:0] snp_data_i;

  always #5 clk = ~clk;

  std_cache_snoop_buffer #(
    .AC_DEPTH   (DEPTH),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .ac_valid_i       (ac_valid_i),
    .ac_ready_o       (ac_ready_o),
    .ac_addr_i        (ac_addr_i),
    .ac_snoop_i       (ac_snoop_i),
    .cr_valid_o       (cr_valid_o),
    .cr_ready_i       (cr_ready_i),
    .cr_resp_o        (cr_resp_o),
    .cd_valid_o       (cd_valid_o),
    .cd_ready_i       (cd_ready_i),
    .cd_data_o        (cd_data_o),
    .cd_last_o        (cd_last_o),
    .snp_req_valid_o  (snp_req_valid_o),
    .snp_req_ready_i  (snp_req_ready_i),
    .snp_req_addr_o   (snp_req_addr_o),
    .snp_req_snoop_o  (snp_req_snoop_o),
    .snp_resp_valid_i (snp_resp_valid_i),
    .snp_resp_i       (snp_resp_i),
    .snp_data_i       (snp_data_i)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    snoop;
  } ac_t;

  typedef struct packed {
    logic [4:0]    resp;
    logic [LW-1:0] line;
  } rsp_t;

  // Upstream/cache stimulus sources
  ac_t  ac_src[$];
  rsp_t rsp_src[$];
  ac_t  ac_last;

  // Reference model state
  ac_t  pending[$];
  bit   inflight, resp_known, cr_done;
  int   beats;
  rsp_t cur;
  bit   cache_wait;
  int   cache_delay;
  bit   ac_hs, req_hs, rsp_hs, cr_hs, cd_hs;
  bit   exp_ac_ready, exp_req_valid, exp_cr_valid, exp_cd_valid, exp_last;
  logic [LW-1:0] shifted;

  // Traffic knobs
  int ac_gap_pct = 0;
  int req_pct    = 100;
  int cr_pct     = 100;
  int cd_pct     = 100;
  bit cd_toggle  = 0;

  int n_vec  = 0;
  int n_err  = 0;
  int dut_cr = 0;
  int dut_cd = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic ac_t rand_ac();
    ac_t e;
    e.addr  = {$urandom, $urandom};
    e.snoop = 4'($urandom_range(15));
    return e;
  endfunction

  task automatic clear_model();
    pending.delete();
    inflight = 0; resp_known = 0; cr_done = 0; beats = 0;
    cache_wait = 0; cache_delay = 0;
    ac_hs = 0; req_hs = 0; rsp_hs = 0; cr_hs = 0; cd_hs = 0;
  endtask

  task automatic idle_inputs();
    ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0;
    cr_ready_i = 0; cd_ready_i = 0; snp_req_ready_i = 0;
    snp_resp_valid_i = 0; snp_resp_i = '0; snp_data_i = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_req_valid"}, snp_req_valid_o, 1'b0);
    check_eq({tag, "_req_addr"},  snp_req_addr_o, '0);
    check_eq({tag, "_cr_valid"},  cr_valid_o, 1'b0);
    check_eq({tag, "_cr_resp"},   cr_resp_o, '0);
    check_eq({tag, "_cd_valid"},  cd_valid_o, 1'b0);
    check_eq({tag, "_cd_data"},   cd_data_o, '0);
    check_eq({tag, "_cd_last"},   cd_last_o, 1'b0);
  endtask

  // One clock: retire the handshakes of the previous cycle into the model,
  // compare outputs, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (ac_hs) pending.push_back(ac_last);
    if (req_hs) begin
      void'(pending.pop_front());
      inflight = 1; resp_known = 0; cr_done = 0; beats = 0;
      cache_wait = 1; cache_delay = $urandom_range(3);
    end
    if (rsp_hs) resp_known = 1;
    if (cr_hs) begin
      cr_done = 1;
      if (!cur.resp[0]) inflight = 0;
    end
    if (cd_hs) begin
      beats++;
      if (beats == NBEATS) inflight = 0;
    end

    exp_ac_ready  = pending.size() < DEPTH;
    exp_req_valid = !inflight && pending.size() != 0;
    exp_cr_valid  = inflight && resp_known && !cr_done;
    exp_cd_valid  = inflight && cr_done;
    exp_last      = exp_cd_valid && (beats == NBEATS - 1);

    check_eq("ac_ready",  ac_ready_o, exp_ac_ready);
    check_eq("req_valid", snp_req_valid_o, exp_req_valid);
    check_eq("cr_valid",  cr_valid_o, exp_cr_valid);
    check_eq("cd_valid",  cd_valid_o, exp_cd_valid);
    check_eq("cd_last",   cd_last_o, exp_last);
    if (exp_req_valid) begin
      check_eq("req_addr",  snp_req_addr_o, pending[0].addr);
      check_eq("req_snoop", snp_req_snoop_o, pending[0].snoop);
    end
    if (exp_cr_valid) check_eq("cr_resp", cr_resp_o, cur.resp);
    if (exp_cd_valid) begin
      shifted = cur.line >> (beats * DW);
      check_eq("cd_data", cd_data_o, shifted[DW-1:0]);
    end

    // Cache side: answer an issued request after a short random delay.
    rsp_hs = 0;
    snp_resp_valid_i = 0;
    snp_resp_i = 5'($urandom);
    snp_data_i = rand_line();
    if (cache_wait) begin
      if (cache_delay == 0) begin
        if (rsp_src.size() != 0) cur = rsp_src.pop_front();
        else begin
          cur.resp = 5'($urandom);
          cur.line = rand_line();
        end
        snp_resp_valid_i = 1;
        snp_resp_i = cur.resp;
        snp_data_i = cur.line;
        rsp_hs = 1;
        cache_wait = 0;
      end else begin
        cache_delay--;
      end
    end

    // AC side: offer the head of the source queue.
    ac_hs = 0;
    ac_valid_i = 0;
    ac_addr_i = {$urandom, $urandom};
    ac_snoop_i = 4'($urandom);
    if (ac_src.size() != 0 && $urandom_range(99) >= ac_gap_pct) begin
      ac_valid_i = 1;
      ac_addr_i  = ac_src[0].addr;
      ac_snoop_i = ac_src[0].snoop;
      if (exp_ac_ready) begin
        ac_hs = 1;
        ac_last = ac_src.pop_front();
      end
    end

    snp_req_ready_i = ($urandom_range(99) < req_pct);
    cr_ready_i = ($urandom_range(99) < cr_pct);
    cd_ready_i = cd_toggle ? ~cd_ready_i : ($urandom_range(99) < cd_pct);
    req_hs = exp_req_valid && snp_req_ready_i;
    cr_hs  = exp_cr_valid && cr_ready_i;
    cd_hs  = exp_cd_valid && cd_ready_i;
    if (cr_valid_o && cr_ready_i) dut_cr++;
    if (cd_valid_o && cd_ready_i) dut_cd++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_ni = 0;
    idle_inputs();
    clear_model();
    #1;
    check_quiet("rst_async");
    @(posedge clk);
    #1;
    check_quiet("rst_held");
    rst_ni = 1;
  endtask

  int c0, d0;
  bit found;

  initial begin
    rst_ni = 0;
    idle_inputs();
    clear_model();
    #2;
    check_quiet("por");
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1;

    // 1: single clean snoop
    c0 = dut_cr; d0 = dut_cd;
    ac_src.push_back('{addr: 64'h8000_0040, snoop: 4'h1});
    rsp_src.push_back('{resp: 5'h00, line: rand_line()});
    run(12);
    check_eq("t1_cr_count", dut_cr - c0, 1);
    check_eq("t1_cd_count", dut_cd - d0, 0);

    // 2: dirty line with data transfer
    c0 = dut_cr; d0 = dut_cd;
    ac_src.push_back(rand_ac());
    rsp_src.push_back('{resp: 5'h05,
                        line: {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}});
    run(14);
    check_eq("t2_cr_count", dut_cr - c0, 1);
    check_eq("t2_cd_count", dut_cd - d0, NBEATS);

    // 3: backpressure on CR then toggling CD ready
    c0 = dut_cr; d0 = dut_cd;
    cr_pct = 0;
    ac_src.push_back(rand_ac());
    rsp_src.push_back('{resp: 5'h0B, line: rand_line()});
    run(10);
    check_eq("t3_cr_held", cr_valid_o, 1'b1);
    cr_pct = 100;
    cd_toggle = 1;
    run(10);
    cd_toggle = 0;
    check_eq("t3_cr_count", dut_cr - c0, 1);
    check_eq("t3_cd_count", dut_cd - d0, NBEATS);

    // 4/5: fill the FIFO with the cache stalled, then drain back-to-back
    c0 = dut_cr;
    req_pct = 0;
    for (int i = 0; i < 5; i++) ac_src.push_back(rand_ac());
    run(7);
    check_eq("t4_fifo_full", ac_ready_o, 1'b0);
    req_pct = 100;
    run(80);
    check_eq("t5_cr_count", dut_cr - c0, 5);

    // 6: reset after the first CD beat
    d0 = dut_cd;
    ac_src.push_back(rand_ac());
    rsp_src.push_back('{resp: 5'h01, line: rand_line()});
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (dut_cd == d0 + 1) found = 1;
    end
    check_eq("t6_beat0_seen", found, 1'b1);
    cd_pct = 0;
    step();
    apply_reset();
    cd_pct = 100;
    d0 = dut_cd;
    ac_src.push_back(rand_ac());
    rsp_src.push_back('{resp: 5'h01, line: rand_line()});
    run(14);
    check_eq("t6_cd_count", dut_cd - d0, NBEATS);

    // Randomized traffic
    ac_gap_pct = 40;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        req_pct = $urandom_range(30, 100);
        cr_pct  = $urandom_range(30, 100);
        cd_pct  = $urandom_range(30, 100);
      end
      if (ac_src.size() < 3) ac_src.push_back(rand_ac());
      step();
    end
    ac_src.delete();
    req_pct = 100; cr_pct = 100; cd_pct = 100;
    run(80);
    check_eq("drain_idle", pending.size() == 0 && !inflight, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
